tri_wave_gen: RTL and testbench

TRI_WAVE_GEN -- requirements
Module: tri_wave_gen

---
 rtl/tri_wave_gen_if.sv | 27 ++
 rtl/tri_wave_gen.sv | 54 +++++
 tb/tb_tri_wave_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_wave_gen_if.sv
// Signal bundle for the triangle generator: control inputs, the quarter-wave
// table port and the sample output.
interface tri_wave_gen_if #(
   parameter int ACC_W = 32
) ();
   logic             en;
   logic [ACC_W-1:0] fword_in;
   logic             fword_load;
   logic [7:0]       phase_off;
   logic             phase_clr;
   logic [5:0]       tbl_addr;
   logic [8:0]       tbl_data;
   logic [9:0]       wave;
   // wave_valid qualifies wave for one cycle. There is no ready: the generator
   // never stalls, so the consumer must take every sample flagged valid.
   logic             wave_valid;

   modport master (
      output en, fword_in, fword_load, phase_off, phase_clr, tbl_data,
      input  tbl_addr, wave, wave_valid
   );

   modport slave (
      input  en, fword_in, fword_load, phase_off, phase_clr, tbl_data,
      output tbl_addr, wave, wave_valid
   );
endinterface

// File: rtl/tri_wave_gen.sv
// Phase-accumulator triangle generator: the accumulator top byte plus an offset
// addresses a quarter-wave table, and stage 2 mirrors/inverts it into a full period.
module tri_wave_gen #(
   parameter int ACC_W = 32
) (
   input logic          clk,
   input logic          rst,
   tri_wave_gen_if.slave bus
);
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] fword;
   logic [7:0]       phase;
   logic             s1_half;
   logic             s1_en;
   logic [5:0]       tbl_addr_r;
   logic [9:0]       wave_r;
   logic             wave_valid_r;

   // Phase is taken from the accumulator before this edge's increment.
   assign phase = acc[ACC_W-1 -: 8] + bus.phase_off;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         fword        <= '0;
         tbl_addr_r   <= '0;
         s1_half      <= 1'b0;
         s1_en        <= 1'b0;
         wave_r       <= 10'd512;
         wave_valid_r <= 1'b0;
      end else begin
         if (bus.fword_load)
            fword <= bus.fword_in;
         if (bus.phase_clr)
            acc <= '0;
         else if (bus.en)
            acc <= acc + fword;

         // Odd quadrants read the table backwards to form the falling slope.
         tbl_addr_r <= phase[6] ? ~phase[5:0] : phase[5:0];
         // Only the upper quadrant bit matters downstream: it selects the half.
         s1_half    <= phase[7];
         s1_en      <= bus.en;

         wave_r       <= s1_half ? (10'd511 - {1'b0, bus.tbl_data})
                                 : (10'd512 + {1'b0, bus.tbl_data});
         wave_valid_r <= s1_en;
      end
   end

   assign bus.tbl_addr   = tbl_addr_r;
   assign bus.wave       = wave_r;
   assign bus.wave_valid = wave_valid_r;
endmodule

// File: tb/tb_tri_wave_gen.sv
// Bench for tri_wave_gen: table vectors, directed corner sequences and random
// stimulus checked against a phase-level reference model.
module tb_tri_wave_gen;
   localparam int ACC_W = 32;

   logic clk;
   logic rst;

   tri_wave_gen_if #(.ACC_W(ACC_W)) ifc ();

   tri_wave_gen #(.ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   // External quarter-wave table: Q(a) = 8*a + 7.
   assign ifc.tbl_data = {ifc.tbl_addr, 3'b111};

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int n_chk = 0;
   int n_err = 0;

   logic [ACC_W-1:0] m_acc;
   logic [ACC_W-1:0] m_fword;
   bit               m_live = 0;
   // Pending samples: {valid, wave[9:0], addr[5:0]}
   logic [16:0]      exp_q[$];
   int               e_wave;
   int               e_addr;
   bit               e_valid;

   function automatic int cur_p();
      return (int'(m_acc[ACC_W-1 -: 8]) + int'(ifc.phase_off)) % 256;
   endfunction

   // Distance into the current half-period, folded so both slopes share it.
   function automatic int fold(int p);
      int h;
      h = p % 128;
      return (h < 64) ? h : 127 - h;
   endfunction

   function automatic int tri_of(int p);
      int mag;
      mag = 8 * fold(p) + 7;
      return (p < 128) ? 512 + mag : 511 - mag;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: model the edge, then compare on the falling edge.
   task automatic tick();
      int p;
      logic [16:0] ent;
      logic [16:0] old;
      p = cur_p();
      @(posedge clk);
      if (rst) begin
         m_acc   = '0;
         m_fword = '0;
         exp_q.delete();
         exp_q.push_back({1'b0, 10'(tri_of(0)), 6'd0});
         e_wave  = 512;
         e_valid = 1'b0;
         e_addr  = 0;
         m_live  = 1;
      end else begin
         ent = {ifc.en, 10'(tri_of(p)), 6'(fold(p))};
         exp_q.push_back(ent);
         old     = exp_q.pop_front();
         e_valid = old[16];
         e_wave  = int'(old[15:6]);
         e_addr  = fold(p);
         if (ifc.phase_clr)   m_acc = '0;
         else if (ifc.en)     m_acc = m_acc + m_fword;
         if (ifc.fword_load)  m_fword = ifc.fword_in;
      end
      @(negedge clk);
      if (m_live) begin
         chk("model_wave", 32'(ifc.wave), 32'(e_wave));
         chk("model_valid", 32'(ifc.wave_valid), 32'(e_valid));
         chk("model_addr", 32'(ifc.tbl_addr), 32'(e_addr));
      end
   endtask

   task automatic idle_inputs();
      ifc.en         = 1'b0;
      ifc.fword_in   = '0;
      ifc.fword_load = 1'b0;
      ifc.phase_off  = 8'd0;
      ifc.phase_clr  = 1'b0;
   endtask

   task automatic run_until_p(input int target);
      int k;
      k = 0;
      while (cur_p() != target && k < 600) begin
         tick();
         k++;
      end
      chk("reach_phase", 32'(cur_p()), 32'(target));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] off;
      int         exp_wave;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{8'd0,   519};
      vt[1] = '{8'd63,  1023};
      vt[2] = '{8'd64,  1023};
      vt[3] = '{8'd127, 519};
      vt[4] = '{8'd128, 504};
      vt[5] = '{8'd191, 0};
      vt[6] = '{8'd192, 0};
      vt[7] = '{8'd255, 504};
      vt[8] = '{8'd1,   527};
      vt[9] = '{8'd129, 496};

      rst = 1'b1;
      idle_inputs();
      @(negedge clk);

      // Reset held three cycles with random inputs.
      for (int i = 0; i < 3; i++) begin
         ifc.en         = 1'($urandom_range(0, 1));
         ifc.fword_in   = $urandom;
         ifc.fword_load = 1'($urandom_range(0, 1));
         ifc.phase_off  = 8'($urandom_range(0, 255));
         ifc.phase_clr  = 1'($urandom_range(0, 1));
         tick();
         chk("rst_wave", 32'(ifc.wave), 32'd512);
         chk("rst_valid", 32'(ifc.wave_valid), 32'd0);
         chk("rst_addr", 32'(ifc.tbl_addr), 32'd0);
      end
      rst = 1'b0;
      idle_inputs();

      // Static phase points (fword=0, acc cleared, phase set by offset).
      for (int i = 0; i < 10; i++) begin
         ifc.phase_clr  = 1'b1;
         ifc.fword_load = 1'b1;
         ifc.fword_in   = '0;
         ifc.en         = 1'b1;
         ifc.phase_off  = vt[i].off;
         tick();
         ifc.phase_clr  = 1'b0;
         ifc.fword_load = 1'b0;
         tick();
         tick();
         chk($sformatf("vec_wave_%0d", i), 32'(ifc.wave), 32'(vt[i].exp_wave));
         chk($sformatf("vec_valid_%0d", i), 32'(ifc.wave_valid), 32'd1);
      end

      // Full-period sweep at one phase step per cycle.
      ifc.phase_off  = 8'd0;
      ifc.fword_in   = 32'h0100_0000;
      ifc.fword_load = 1'b1;
      ifc.phase_clr  = 1'b1;
      tick();
      ifc.fword_load = 1'b0;
      ifc.phase_clr  = 1'b0;
      for (int i = 0; i < 300; i++) tick();

      // Clear at p=100: next sampled phase is 0, then 1.
      run_until_p(100);
      ifc.phase_clr = 1'b1;
      tick();
      ifc.phase_clr = 1'b0;
      tick();
      tick();
      chk("clr_wave_p0", 32'(ifc.wave), 32'd519);
      tick();
      chk("clr_wave_p1", 32'(ifc.wave), 32'd527);
      for (int i = 0; i < 20; i++) tick();

      // Load while idle.
      ifc.en         = 1'b0;
      ifc.fword_in   = 32'h0200_0000;
      ifc.fword_load = 1'b1;
      tick();
      ifc.fword_load = 1'b0;
      tick();
      tick();
      chk("idle_valid", 32'(ifc.wave_valid), 32'd0);
      ifc.en = 1'b1;
      for (int i = 0; i < 200; i++) tick();

      // Reset mid-operation at p=150.
      ifc.fword_in   = 32'h0100_0000;
      ifc.fword_load = 1'b1;
      tick();
      ifc.fword_load = 1'b0;
      run_until_p(150);
      rst = 1'b1;
      tick();
      chk("midrst_wave", 32'(ifc.wave), 32'd512);
      chk("midrst_valid", 32'(ifc.wave_valid), 32'd0);
      rst = 1'b0;
      tick();
      tick();
      chk("midrst_settle_wave", 32'(ifc.wave), 32'd519);
      chk("midrst_settle_valid", 32'(ifc.wave_valid), 32'd1);
      tick();
      chk("midrst_hold_wave", 32'(ifc.wave), 32'd519);

      // Random stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         ifc.en         = ($urandom_range(0, 9) != 0);
         ifc.fword_load = ($urandom_range(0, 15) == 0);
         ifc.fword_in   = $urandom;
         if ($urandom_range(0, 31) == 0)
            ifc.phase_off = 8'($urandom_range(0, 255));
         ifc.phase_clr  = ($urandom_range(0, 63) == 0);
         rst            = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
